ftq_read_arbiter: RTL and testbench
===================================

Name: ftq_read_arbiter

Overview:
- Shares the FTQ read ports between the ROB and the execution pipelines (BRU/LDU/STU) that need ftq startAddr/nextAddr.
- Replaces the fixed rule "ROB overrides read port 0" with a per-cycle arbiter:
  - ROB has priority.
  - Pipelines are served round-robin.
  - A starvation guard protects the pipelines from the ROB.
  - Read data is registered back to each requester one cycle after grant.

Parameters:
- NUM_REQ, 4, requester count; index 0 = ROB, 1..NUM_REQ-1 = pipelines.
- NUM_PORT, 2, FTQ read ports available.
- FTQIDX_W, 5, ftqIdx width.
- XLEN, 64, address width.
- STARVE_LIMIT, 4, consecutive denied cycles before a pipeline requester overrides ROB priority.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- i_req_vld  in  NUM_REQ  read request per requester.
- i_req_ftqIdx  in  NUM_REQ*FTQIDX_W  requested ftqIdx per requester.
- o_req_gnt  out  NUM_REQ  grant, same cycle as request.
- o_ftq_rd_vld  out  NUM_PORT  port in use this cycle.
- o_ftq_rd_idx  out  NUM_PORT*FTQIDX_W  ftqIdx driven to FTQ.
- i_ftq_startAddr  in  NUM_PORT*XLEN  FTQ combinational read data.
- i_ftq_nextAddr  in  NUM_PORT*XLEN  FTQ combinational read data.
- i_squash_vld  in  1  pipeline squash.
- o_rsp_vld  out  NUM_REQ  response valid, one cycle after grant.
- o_rsp_startAddr  out  NUM_REQ*XLEN  registered startAddr.
- o_rsp_nextAddr  out  NUM_REQ*XLEN  registered nextAddr.

Behaviour:
- Reset state (rst=0, asynchronous):
  - o_rsp_vld=0 and o_rsp_* data=0.
  - o_req_gnt=0 and o_ftq_rd_vld=0 while reset is held.
  - Round-robin pointer rr=1.
  - All starvation counters=0.
- Handshake:
  - A requester holds i_req_vld and i_req_ftqIdx stable until o_req_gnt.
  - Grant is combinational in the request cycle.
  - Grant without request never occurs.
- Priority within a cycle:
  - Step 1: starved pipeline requesters (counter ≥ STARVE_LIMIT), lowest index first.
  - Step 2: ROB.
  - Step 3: remaining pipeline requesters in round-robin order starting at rr.
  - Ports are filled lowest index first: port 0 takes the first winner, and so on.
  - At most NUM_PORT grants per cycle.
- Response:
  - Data on port p for grant-cycle requester r is captured into r's response register at the clock edge.
  - o_rsp_vld[r]=1 exactly one cycle after o_req_gnt[r], for one cycle.
- Round-robin pointer:
  - If any pipeline requester is granted, rr moves to the last-granted pipeline index +1, wrapping from NUM_REQ-1 to 1.
  - Otherwise rr holds.
- Starvation counters (pipeline requesters only):
  - Counter i increments, saturating at STARVE_LIMIT, when i_req_vld[i]=1 and not granted.
  - It clears on grant or when i_req_vld[i]=0.
- Squash:
  - i_squash_vld=1 clears all pipeline requesters' o_rsp_vld for the following cycle, including responses captured in the squash cycle.
  - It also clears all starvation counters.
  - The ROB response is unaffected.
  - Grants in the squash cycle still occur.
- Boundary conditions:
  - All requesters active with NUM_PORT=2: exactly two grants.
  - No requests: all outputs 0, rr and counters hold.
  - Reset asserted mid-transaction: pending responses are dropped and not re-issued.
  - Identical ftqIdx from two requesters: two ports are used (see optional feature).

Optional Feature:
- Macro: FTQRD_MERGE_EN.
- Defined:
  - After arbitration order is fixed, any later-ranked requester whose ftqIdx equals an already-granted port's ftqIdx is granted on that port without consuming a new one.
  - The merged requester's response carries that port's data.
  - Freed ports continue to the next-ranked requesters.
  - Round-robin and starvation rules treat merged grants as ordinary grants.
- Not defined: every grant consumes a distinct port.

Test Plan:
- Single request, reset released: req1 ftqIdx=3, FTQ returns start=0x1000, next=0x1020 -> gnt1 same cycle on port 0; next cycle rsp_vld1=1, start=0x1000, next=0x1020; all other outputs 0.
- ROB priority and round-robin: req0..3 held all valid for 3 cycles, rr=1 -> cycle 1 grants {0,1}, cycle 2 {0,2}, cycle 3 {0,3}; rr ends at 1.
- Starvation: NUM_PORT=1, req0 and req2 held valid -> req0 granted for 4 cycles, req2 granted on cycle 5; then req0 granted again with counter2=0.
- Squash: req1 granted in cycle N, squash asserted in N -> rsp_vld1=0 in N+1. req0 granted in N -> rsp_vld0=1 in N+1.
- Reset mid-operation: grant in cycle N, rst=0 asynchronously before edge N+1 -> o_rsp_vld=0 immediately; after release rr=1 and no stale responses.
- Merge, with FTQRD_MERGE_EN: req0 and req1 both ftqIdx=7, req2 ftqIdx=9, NUM_PORT=2 -> all three granted, port 0=7, port 1=9; rsp data for 0 and 1 identical. Without the macro, req2 is not granted.

Source files
------------

// File: rtl/ftq_read_arbiter.sv
// Per-cycle FTQ read-port arbiter: starved pipelines, then ROB, then round-robin pipelines.
// Optional FTQRD_MERGE_EN: a requester whose ftqIdx matches an already-granted port shares that port.
module ftq_read_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int NUM_PORT     = 2,
   parameter int FTQIDX_W     = 5,
   parameter int XLEN         = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           i_req_vld,
   input  logic [NUM_REQ*FTQIDX_W-1:0]  i_req_ftqIdx,
   output logic [NUM_REQ-1:0]           o_req_gnt,
   output logic [NUM_PORT-1:0]          o_ftq_rd_vld,
   output logic [NUM_PORT*FTQIDX_W-1:0] o_ftq_rd_idx,
   input  logic [NUM_PORT*XLEN-1:0]     i_ftq_startAddr,
   input  logic [NUM_PORT*XLEN-1:0]     i_ftq_nextAddr,
   input  logic                         i_squash_vld,
   output logic [NUM_REQ-1:0]           o_rsp_vld,
   output logic [NUM_REQ*XLEN-1:0]      o_rsp_startAddr,
   output logic [NUM_REQ*XLEN-1:0]      o_rsp_nextAddr
);
   localparam int RR_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam int SEL_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

   logic [RR_W-1:0]     rr_q, rr_d;
   logic [CNT_W-1:0]    cnt_q [NUM_REQ];
   logic [CNT_W-1:0]    cnt_d [NUM_REQ];
   logic [NUM_REQ-1:0]  rsp_vld_q, rsp_vld_d;
   logic [XLEN-1:0]     rsp_start_q [NUM_REQ];
   logic [XLEN-1:0]     rsp_next_q  [NUM_REQ];
   logic [NUM_REQ-1:0]  req, starved, gnt;
   logic [SEL_W-1:0]    sel [NUM_REQ];
   logic [NUM_PORT-1:0] port_vld;
   logic [NUM_PORT*FTQIDX_W-1:0] port_idx;

   // NOTE: requests are masked while reset is held so grants and port valids stay low asynchronously.
   assign req = i_req_vld & {NUM_REQ{rst}};

   always_comb begin
      starved = '0;
      for (int r = 1; r < NUM_REQ; r++)
         starved[r] = (cnt_q[r] >= CNT_W'(STARVE_LIMIT));
   end

   always_comb begin
      int                n;
      int                rk;
      int                last_pipe;
      int                ord [NUM_REQ];
      logic              placed;
      logic [FTQIDX_W-1:0] cur_idx;
      gnt       = '0;
      port_vld  = '0;
      port_idx  = '0;
      n         = 0;
      rk        = 0;
      last_pipe = 0;
      placed    = 1'b0;
      cur_idx   = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         sel[r] = '0;
         ord[r] = 0;
      end
      // Build the ranking: starved pipelines, ROB, then pipelines in round-robin order from rr.
      for (int r = 1; r < NUM_REQ; r++)
         if (req[r] && starved[r]) begin
            ord[n] = r;
            n      = n + 1;
         end
      if (req[0]) begin
         ord[n] = 0;
         n      = n + 1;
      end
      for (int k = 0; k < NUM_REQ - 1; k++) begin
         rk = int'(rr_q) + k;
         if (rk >= NUM_REQ) rk = rk - (NUM_REQ - 1);
         if (req[rk] && !starved[rk]) begin
            ord[n] = rk;
            n      = n + 1;
         end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (k < n) begin
            placed  = 1'b0;
            cur_idx = i_req_ftqIdx[ord[k]*FTQIDX_W +: FTQIDX_W];
`ifdef FTQRD_MERGE_EN
            for (int p = 0; p < NUM_PORT; p++)
               if (!placed && port_vld[p] && port_idx[p*FTQIDX_W +: FTQIDX_W] == cur_idx) begin
                  sel[ord[k]] = SEL_W'(p);
                  placed      = 1'b1;
               end
`endif
            for (int p = 0; p < NUM_PORT; p++)
               if (!placed && !port_vld[p]) begin
                  port_vld[p]                       = 1'b1;
                  port_idx[p*FTQIDX_W +: FTQIDX_W]  = cur_idx;
                  sel[ord[k]]                       = SEL_W'(p);
                  placed                            = 1'b1;
               end
            if (placed) begin
               gnt[ord[k]] = 1'b1;
               if (ord[k] != 0) last_pipe = ord[k];
            end
         end
      end
      rr_d = rr_q;
      if (last_pipe != 0)
         rr_d = (last_pipe == NUM_REQ - 1) ? RR_W'(1) : RR_W'(last_pipe + 1);
   end

   always_comb begin
      for (int r = 0; r < NUM_REQ; r++) cnt_d[r] = '0;
      for (int r = 1; r < NUM_REQ; r++)
         if (!i_squash_vld && req[r] && !gnt[r])
            cnt_d[r] = starved[r] ? cnt_q[r] : cnt_q[r] + 1'b1;
      rsp_vld_d = gnt;
      if (i_squash_vld) rsp_vld_d[NUM_REQ-1:1] = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_q      <= RR_W'(1);
         rsp_vld_q <= '0;
         for (int r = 0; r < NUM_REQ; r++) begin
            cnt_q[r]       <= '0;
            rsp_start_q[r] <= '0;
            rsp_next_q[r]  <= '0;
         end
      end else begin
         rr_q      <= rr_d;
         rsp_vld_q <= rsp_vld_d;
         for (int r = 0; r < NUM_REQ; r++) begin
            cnt_q[r] <= cnt_d[r];
            for (int p = 0; p < NUM_PORT; p++)
               if (gnt[r] && sel[r] == SEL_W'(p)) begin
                  rsp_start_q[r] <= i_ftq_startAddr[p*XLEN +: XLEN];
                  rsp_next_q[r]  <= i_ftq_nextAddr[p*XLEN +: XLEN];
               end
         end
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_REQ; r++) begin
         o_rsp_startAddr[r*XLEN +: XLEN] = rsp_start_q[r];
         o_rsp_nextAddr[r*XLEN +: XLEN]  = rsp_next_q[r];
      end
   end

   assign o_req_gnt    = gnt;
   assign o_ftq_rd_vld = port_vld;
   assign o_ftq_rd_idx = port_idx;
   assign o_rsp_vld    = rsp_vld_q;

endmodule

// File: tb/tb_ftq_read_arbiter.sv
// Directed bench for ftq_read_arbiter: a 2-port instance for the main flow and a 1-port
// instance for the starvation guard; the FTQ is modelled as a small lookup table.
module tb_ftq_read_arbiter;
   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_vld;
   logic [19:0]  req_idx;
   logic [3:0]   gnt;
   logic [1:0]   rd_vld;
   logic [9:0]   rd_idx;
   logic [127:0] ftq_start, ftq_next;
   logic         squash;
   logic [3:0]   rsp_vld;
   logic [255:0] rsp_start, rsp_next;

   logic [3:0]   s_req_vld;
   logic [19:0]  s_req_idx;
   logic [3:0]   s_gnt;
   logic [0:0]   s_rd_vld;
   logic [4:0]   s_rd_idx;
   logic [63:0]  s_start, s_next;
   logic         s_squash;
   logic [3:0]   s_rsp_vld;
   logic [255:0] s_rsp_start, s_rsp_next;

   logic [63:0]  ftq_mem [32];
   int           n_checks = 0;
   int           n_errors = 0;

   always #5 clk = ~clk;

   ftq_read_arbiter u_dut (
      .clk(clk), .rst(rst),
      .i_req_vld(req_vld), .i_req_ftqIdx(req_idx), .o_req_gnt(gnt),
      .o_ftq_rd_vld(rd_vld), .o_ftq_rd_idx(rd_idx),
      .i_ftq_startAddr(ftq_start), .i_ftq_nextAddr(ftq_next),
      .i_squash_vld(squash), .o_rsp_vld(rsp_vld),
      .o_rsp_startAddr(rsp_start), .o_rsp_nextAddr(rsp_next)
   );

   ftq_read_arbiter #(.NUM_PORT(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .i_req_vld(s_req_vld), .i_req_ftqIdx(s_req_idx), .o_req_gnt(s_gnt),
      .o_ftq_rd_vld(s_rd_vld), .o_ftq_rd_idx(s_rd_idx),
      .i_ftq_startAddr(s_start), .i_ftq_nextAddr(s_next),
      .i_squash_vld(s_squash), .o_rsp_vld(s_rsp_vld),
      .o_rsp_startAddr(s_rsp_start), .o_rsp_nextAddr(s_rsp_next)
   );

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         ftq_start[p*64 +: 64] = ftq_mem[rd_idx[p*5 +: 5]];
         ftq_next[p*64 +: 64]  = ftq_mem[rd_idx[p*5 +: 5]] + 64'h20;
      end
      s_start = ftq_mem[s_rd_idx];
      s_next  = ftq_mem[s_rd_idx] + 64'h20;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idx(input int r, input logic [4:0] v);
      req_idx[r*5 +: 5] = v;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ftq_mem[i] = 64'h8000_0000 + 64'(i) * 64'h40;
      ftq_mem[3] = 64'h1000;
      rst = 1'b0; req_vld = 4'hF; req_idx = '0; squash = 1'b0;
      s_req_vld = '0; s_req_idx = '0; s_squash = 1'b0;

      // Reset held: no grants even with requests present
      #2;
      check("rst_gnt", gnt, 0);
      check("rst_rd_vld", rd_vld, 0);
      check("rst_rsp_vld", rsp_vld, 0);
      step();
      check("rst_hold_gnt", gnt, 0);
      check("rst_rsp_start1", rsp_start[127:64], 0);
      check("rst_rsp_next1", rsp_next[127:64], 0);
      rst = 1'b1; req_vld = '0;
      step();

      // Single request
      req_vld = 4'b0010; set_idx(1, 3); #1;
      check("single_gnt", gnt, 4'b0010);
      check("single_rd_vld", rd_vld, 2'b01);
      check("single_rd_idx0", rd_idx[4:0], 3);
      step(); req_vld = '0;
      check("single_rsp_vld", rsp_vld, 4'b0010);
      check("single_rsp_start", rsp_start[127:64], 64'h1000);
      check("single_rsp_next", rsp_next[127:64], 64'h1020);
      check("single_rsp_other", rsp_start[63:0], 0);
      #1;
      check("idle_gnt", gnt, 0);
      check("idle_rd_vld", rd_vld, 0);
      step();
      check("single_rsp_once", rsp_vld, 0);

      // Reset mid-operation drops pending responses
      req_vld = 4'b0010; set_idx(1, 5); #1;
      check("mid_gnt1", gnt, 4'b0010);
      step(); req_vld = 4'b0100; set_idx(2, 6); #1;
      check("mid_rsp_vld", rsp_vld, 4'b0010);
      check("mid_gnt2", gnt, 4'b0100);
      #2; rst = 1'b0; #1;
      check("mid_rst_rsp_vld", rsp_vld, 0);
      check("mid_rst_gnt", gnt, 0);
      step(); step(); rst = 1'b1; req_vld = '0;
      step();
      check("mid_no_stale", rsp_vld, 0);

      // ROB priority plus round-robin from rr=1
      req_vld = 4'hF;
      for (int r = 0; r < 4; r++) set_idx(r, 5'(10 + r));
      #1;
      check("rr1_gnt", gnt, 4'b0011);
      check("rr1_rd_idx", rd_idx, {5'd11, 5'd10});
      step();
      check("rr1_rsp_vld", rsp_vld, 4'b0011);
      check("rr1_rsp_start1", rsp_start[127:64], ftq_mem[11]);
      #1;
      check("rr2_gnt", gnt, 4'b0101);
      step(); #1;
      check("rr3_gnt", gnt, 4'b1001);
      step();
      check("rr3_rsp_vld", rsp_vld, 4'b1001);
      check("rr3_rsp_start3", rsp_start[255:192], ftq_mem[13]);
      req_vld = 4'b1110; #1;
      check("rr_wrap_gnt", gnt, 4'b0110);
      check("rr_wrap_rd_idx", rd_idx, {5'd12, 5'd11});
      step();

      // Squash: rr=3 now, ROB and req1 granted, only ROB responds
      req_vld = 4'b0011; set_idx(0, 20); set_idx(1, 21); squash = 1'b1; #1;
      check("sq_gnt", gnt, 4'b0011);
      step(); squash = 1'b0; req_vld = '0;
      check("sq_rsp_vld", rsp_vld, 4'b0001);
      check("sq_rob_start", rsp_start[63:0], ftq_mem[20]);
      check("sq_rob_next", rsp_next[63:0], ftq_mem[20] + 64'h20);

      // Identical ftqIdx, fresh reset so rr=1
      rst = 1'b0; #2; step(); rst = 1'b1;
      req_vld = 4'b0111; set_idx(0, 7); set_idx(1, 7); set_idx(2, 9); #1;
`ifdef FTQRD_MERGE_EN
      check("merge_gnt", gnt, 4'b0111);
      check("merge_rd_idx", rd_idx, {5'd9, 5'd7});
`else
      check("merge_gnt", gnt, 4'b0011);
      check("merge_rd_idx", rd_idx, {5'd7, 5'd7});
`endif
      step(); req_vld = '0;
      check("merge_rsp_start0", rsp_start[63:0], ftq_mem[7]);
      check("merge_rsp_start1", rsp_start[127:64], ftq_mem[7]);
`ifdef FTQRD_MERGE_EN
      check("merge_rsp_vld", rsp_vld, 4'b0111);
      check("merge_rsp_start2", rsp_start[191:128], ftq_mem[9]);
`else
      check("merge_rsp_vld", rsp_vld, 4'b0011);
`endif

      // Starvation guard on the single-port instance
      s_req_vld = 4'b0101; s_req_idx = {5'd0, 5'd2, 5'd0, 5'd1};
      for (int c = 1; c <= 4; c++) begin
         #1;
         check($sformatf("starve_rob_c%0d", c), s_gnt, 4'b0001);
         step();
      end
      #1;
      check("starve_win", s_gnt, 4'b0100);
      check("starve_rd_idx", s_rd_idx, 2);
      step();
      check("starve_rsp_vld", s_rsp_vld, 4'b0100);
      check("starve_rsp_start", s_rsp_start[191:128], ftq_mem[2]);
      #1;
      check("starve_after", s_gnt, 4'b0001);
      step(); #1;
      check("starve_c7", s_gnt, 4'b0001);
      step(); #1;
      check("starve_c8", s_gnt, 4'b0001);
      step();
      s_squash = 1'b1; #1;
      check("starve_sq_gnt", s_gnt, 4'b0001);
      step(); s_squash = 1'b0;
      check("starve_sq_rob_rsp", s_rsp_vld, 4'b0001);
      #1;
      check("starve_sq_clears_cnt", s_gnt, 4'b0001);
      s_req_vld = '0;
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
